// File: rtl/fetch_pkg.sv
// Shared types and constants for the WISC instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 16;
  localparam int unsigned OPC_W   = 5;

  localparam logic [OPC_W-1:0] HALT_OPCODE = 5'b00000;
  localparam logic [PC_W-1:0]  PC_INC      = 16'd2;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: OPC_W] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small FIFO holding fetched {pc, instr} entries between memory and decode.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = PC_W + INSTR_W,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers and occupancy; flush wins over any same-cycle push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// WISC fetch stage: PC owner, single-outstanding imem requester, decode buffer.
// Build option FETCH_ALIGN_CHECK_EN: odd redirect targets raise sticky err and halt.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic [15:0] pc_plus2,
  input  logic        stall,
  output logic        halted,
  output logic        err
);

  localparam int unsigned CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned ENTRY_W = PC_W + INSTR_W;

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  req_pc_q, req_pc_d;
  logic [PC_W-1:0]  redirect_tgt;
  logic             outstanding_q, outstanding_d;
  logic             drop_q, drop_d;
  logic             req_q, req_d;
  logic             fire, rsp, misalign;
  logic             buf_push, buf_pop, buf_flush, buf_full, buf_empty;
  logic [CNT_W-1:0] buf_count, count_next;
  logic [ENTRY_W-1:0] buf_head;
  fetch_entry_t     head_entry, push_entry;

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q;
  assign redirect_tgt = redirect_pc;
  assign misalign     = redirect & redirect_pc[0];
  assign err          = err_q;
`else
  assign redirect_tgt = redirect_pc & ~PC_W'(1);
  assign misalign     = 1'b0;
  assign err          = 1'b0;
`endif

  assign fire = req_q & imem_ready;
  assign rsp  = imem_valid & outstanding_q;

  // Next-state: issue, response, then redirect overriding everything else.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    buf_push      = 1'b0;
    buf_flush     = 1'b0;
    buf_pop       = ~buf_empty & ~stall;

    if (fire) begin
      outstanding_d = 1'b1;
      req_pc_d      = pc_q;
      pc_d          = pc_q + PC_INC;
    end

    if (rsp) begin
      outstanding_d = 1'b0;
      drop_d        = 1'b0;
      if (!drop_q && (!buf_full || buf_pop)) begin
        buf_push = 1'b1;
        if (is_halt(imem_rdata)) state_d = HALT;
      end
    end

    // A request still in flight after redirect belongs to the old path.
    if (redirect) begin
      buf_flush = 1'b1;
      buf_push  = 1'b0;
      pc_d      = redirect_tgt;
      state_d   = misalign ? HALT : RUN;
      drop_d    = fire | (outstanding_q & ~imem_valid);
    end

    count_next = buf_flush ? '0 : buf_count + CNT_W'(buf_push) - CNT_W'(buf_pop);
    req_d      = (state_d == RUN) & ~outstanding_d & (count_next < CNT_W'(BUF_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      req_pc_q      <= RESET_PC;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      req_q         <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      req_q         <= req_d;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q         <= err_q | misalign;
`endif
    end
  end

  assign push_entry = '{pc: req_pc_q, instr: imem_rdata};

  fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_data (push_entry),
    .pop       (buf_pop),
    .flush     (buf_flush),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty),
    .head      (buf_head)
  );

  assign head_entry  = buf_head;
  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = ~buf_empty;
  assign instr       = head_entry.instr;
  assign instr_pc    = head_entry.pc;
  assign pc_plus2    = head_entry.pc + PC_INC;
  assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; second instance covers RESET_PC wrap-around.
module tb_fetch_unit;

  logic        clk, rst_n;
  logic        redirect, stall, imem_ready, imem_valid, imem_req;
  logic [15:0] redirect_pc, imem_addr, imem_rdata;
  logic        instr_valid, halted, err;
  logic [15:0] instr, instr_pc, pc_plus2;

  logic        w_redirect, w_stall, w_ready, w_valid, w_req;
  logic [15:0] w_redirect_pc, w_addr, w_rdata;
  logic        w_instr_valid, w_halted, w_err;
  logic [15:0] w_instr, w_instr_pc, w_pc_plus2;

  int checks = 0;
  int errors = 0;

  int          mem_lat = 1;
  int          mem_cnt;
  logic        mem_busy;
  logic [15:0] mem_paddr;
  logic [15:0] halt_addr = 16'h0001;

  logic [15:0] fire_q[$], pop_pc_q[$], pop_instr_q[$], pop_p2_q[$];
  logic [15:0] w_fire_q[$], w_pop_pc_q[$], w_pop_p2_q[$];

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .pc_plus2(pc_plus2), .stall(stall),
    .halted(halted), .err(err)
  );

  fetch_unit #(.RESET_PC(16'hFFFC)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_ready),
    .imem_valid(w_valid), .imem_rdata(w_rdata), .instr_valid(w_instr_valid),
    .instr(w_instr), .instr_pc(w_instr_pc), .pc_plus2(w_pc_plus2), .stall(w_stall),
    .halted(w_halted), .err(w_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == halt_addr) return 16'h0000;
    return {8'hA5, a[7:0]};
  endfunction

  // Instruction memory with configurable latency; forgets in-flight reads on reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_valid <= 1'b0;
      imem_rdata <= 16'h0000;
      mem_busy   <= 1'b0;
      mem_cnt    <= 0;
      mem_paddr  <= 16'h0000;
    end else begin
      imem_valid <= 1'b0;
      if (imem_req && imem_ready) begin
        if (mem_lat <= 1) begin
          imem_valid <= 1'b1;
          imem_rdata <= mem_word(imem_addr);
        end else begin
          mem_busy  <= 1'b1;
          mem_cnt   <= mem_lat - 1;
          mem_paddr <= imem_addr;
        end
      end else if (mem_busy) begin
        if (mem_cnt == 1) begin
          imem_valid <= 1'b1;
          imem_rdata <= mem_word(mem_paddr);
          mem_busy   <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid <= 1'b0;
      w_rdata <= 16'h0000;
    end else begin
      w_valid <= w_req & w_ready;
      if (w_req && w_ready) w_rdata <= {8'hA5, w_addr[7:0]};
    end
  end

  // Transaction log: request fires and instructions accepted by decode.
  always @(posedge clk) begin
    if (rst_n) begin
      if (imem_req && imem_ready) fire_q.push_back(imem_addr);
      if (instr_valid && !stall) begin
        pop_pc_q.push_back(instr_pc);
        pop_instr_q.push_back(instr);
        pop_p2_q.push_back(pc_plus2);
      end
      if (w_req && w_ready && w_fire_q.size() < 8) w_fire_q.push_back(w_addr);
      if (w_instr_valid && !w_stall && w_pop_pc_q.size() < 8) begin
        w_pop_pc_q.push_back(w_instr_pc);
        w_pop_p2_q.push_back(w_pc_plus2);
      end
    end
  end

  task automatic clear_logs();
    fire_q.delete(); pop_pc_q.delete(); pop_instr_q.delete(); pop_p2_q.delete();
    w_fire_q.delete(); w_pop_pc_q.delete(); w_pop_p2_q.delete();
  endtask

  task automatic do_reset(input int lat, input logic stl);
    @(negedge clk);
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    stall = stl; mem_lat = lat;
    clear_logs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_pops(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pop_pc_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_fires(input int n, input int budget, input bit use_w, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((use_w ? w_fire_q.size() : fire_q.size()) >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; redirect = 1'b0; stall = 1'b0; mem_lat = 1;
    clear_logs();
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h exp 0000", imem_addr); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL first_addr got %h exp 0000", imem_addr); end
  endtask

  task automatic test_basic();
    logic [15:0] exp_pc[3] = '{16'h0000, 16'h0002, 16'h0004};
    logic [15:0] exp_in[3] = '{16'hA500, 16'hA502, 16'hA504};
    logic [15:0] exp_p2[3] = '{16'h0002, 16'h0004, 16'h0006};
    bit ok;
    do_reset(1, 1'b0);
    wait_pops(3, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got %0d pops exp 3", pop_pc_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (fire_q[i] !== exp_pc[i]) begin errors++; $display("FAIL basic_addr[%0d] got %h exp %h", i, fire_q[i], exp_pc[i]); end
      checks++; if (pop_pc_q[i] !== exp_pc[i]) begin errors++; $display("FAIL basic_pc[%0d] got %h exp %h", i, pop_pc_q[i], exp_pc[i]); end
      checks++; if (pop_instr_q[i] !== exp_in[i]) begin errors++; $display("FAIL basic_instr[%0d] got %h exp %h", i, pop_instr_q[i], exp_in[i]); end
      checks++; if (pop_p2_q[i] !== exp_p2[i]) begin errors++; $display("FAIL basic_pc_plus2[%0d] got %h exp %h", i, pop_p2_q[i], exp_p2[i]); end
    end
  endtask

  task automatic test_stall();
    logic [15:0] exp_pc[4] = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
    bit ok;
    do_reset(1, 1'b1);
    repeat (8) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_full got %b exp 0", imem_req); end
    checks++; if (fire_q.size() != 2) begin errors++; $display("FAIL stall_fires got %0d exp 2", fire_q.size()); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b exp 1", instr_valid); end
    repeat (2) @(negedge clk);
    checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL stall_head_pc got %h exp 0000", instr_pc); end
    checks++; if (instr !== 16'hA500) begin errors++; $display("FAIL stall_head_instr got %h exp A500", instr); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_hold got %b exp 0", imem_req); end
    stall = 1'b0;
    wait_pops(4, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got %0d pops exp 4", pop_pc_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (pop_pc_q[i] !== exp_pc[i]) begin errors++; $display("FAIL stall_order[%0d] got %h exp %h", i, pop_pc_q[i], exp_pc[i]); end
    end
  endtask

  task automatic test_redirect();
    bit ok;
    do_reset(3, 1'b0);
    wait_fires(1, 10, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL redir_fire_timeout got %0d fires exp 1", fire_q.size()); end
    redirect = 1'b1; redirect_pc = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    wait_pops(2, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL redir_timeout got %0d pops exp 2", pop_pc_q.size()); end
    checks++; if (pop_pc_q[0] !== 16'h0040) begin errors++; $display("FAIL redir_pc0 got %h exp 0040", pop_pc_q[0]); end
    checks++; if (pop_instr_q[0] !== 16'hA540) begin errors++; $display("FAIL redir_instr0 got %h exp A540", pop_instr_q[0]); end
    checks++; if (pop_pc_q[1] !== 16'h0042) begin errors++; $display("FAIL redir_pc1 got %h exp 0042", pop_pc_q[1]); end
    checks++; if (fire_q[1] !== 16'h0040) begin errors++; $display("FAIL redir_addr got %h exp 0040", fire_q[1]); end
  endtask

  task automatic test_halt();
    bit ok;
    halt_addr = 16'h0006;
    do_reset(1, 1'b0);
    wait_pops(4, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL halt_timeout got %0d pops exp 4", pop_pc_q.size()); end
    repeat (6) @(negedge clk);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b exp 1", halted); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_req got %b exp 0", imem_req); end
    checks++; if (pop_pc_q.size() != 4) begin errors++; $display("FAIL halt_once got %0d pops exp 4", pop_pc_q.size()); end
    checks++; if (pop_pc_q[3] !== 16'h0006) begin errors++; $display("FAIL halt_pc got %h exp 0006", pop_pc_q[3]); end
    checks++; if (pop_instr_q[3] !== 16'h0000) begin errors++; $display("FAIL halt_instr got %h exp 0000", pop_instr_q[3]); end
    checks++; if (fire_q.size() != 4) begin errors++; $display("FAIL halt_fires got %0d exp 4", fire_q.size()); end
    redirect = 1'b1; redirect_pc = 16'h0010;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_resume got %b exp 0", halted); end
    wait_pops(5, 40, ok);
    checks++; if (pop_pc_q[4] !== 16'h0010) begin errors++; $display("FAIL halt_resume_pc got %h exp 0010", pop_pc_q[4]); end
    checks++; if (pop_instr_q[4] !== 16'hA510) begin errors++; $display("FAIL halt_resume_instr got %h exp A510", pop_instr_q[4]); end
    halt_addr = 16'h0001;
  endtask

  task automatic test_wrap();
    logic [15:0] exp_a[3]  = '{16'hFFFC, 16'hFFFE, 16'h0000};
    logic [15:0] exp_p2[3] = '{16'hFFFE, 16'h0000, 16'h0002};
    bit ok;
    do_reset(1, 1'b0);
    wait_fires(3, 30, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout got %0d fires exp 3", w_fire_q.size()); end
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++; if (w_fire_q[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr[%0d] got %h exp %h", i, w_fire_q[i], exp_a[i]); end
      checks++; if (w_pop_pc_q[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_pc[%0d] got %h exp %h", i, w_pop_pc_q[i], exp_a[i]); end
      checks++; if (w_pop_p2_q[i] !== exp_p2[i]) begin errors++; $display("FAIL wrap_pc_plus2[%0d] got %h exp %h", i, w_pop_p2_q[i], exp_p2[i]); end
    end
    checks++; if ({w_halted, w_err} !== 2'b00) begin errors++; $display("FAIL wrap_flags got %b exp 00", {w_halted, w_err}); end
  endtask

  task automatic test_align();
    bit ok;
    do_reset(1, 1'b1);
    repeat (8) @(negedge clk);
    redirect = 1'b1; redirect_pc = 16'h0013;
    @(negedge clk);
    redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL align_err got %b exp 1", err); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL align_halt got %b exp 1", halted); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL align_flush got %b exp 0", instr_valid); end
    stall = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL align_req got %b exp 0", imem_req); end
    checks++; if (fire_q.size() != 2) begin errors++; $display("FAIL align_fires got %0d exp 2", fire_q.size()); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL align_sticky got %b exp 1", err); end
`else
    stall = 1'b0;
    wait_pops(1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL align_timeout got %0d pops exp 1", pop_pc_q.size()); end
    checks++; if (fire_q[2] !== 16'h0012) begin errors++; $display("FAIL align_addr got %h exp 0012", fire_q[2]); end
    checks++; if (pop_pc_q[0] !== 16'h0012) begin errors++; $display("FAIL align_pc got %h exp 0012", pop_pc_q[0]); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL align_err got %b exp 0", err); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL align_halt got %b exp 0", halted); end
`endif
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; stall = 1'b0; imem_ready = 1'b1;
    w_redirect = 1'b0; w_redirect_pc = 16'h0000; w_stall = 1'b0; w_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
